// File: rtl/tlp_framer.sv
// tlp_framer: round-robin pop from four show-ahead FIFOs and emit each word as a
// 3-beat frame (header, payload, check trailer) over a valid/ready handshake.
module tlp_framer #(
    parameter int unsigned SEQ_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             active,
    input  logic             empty0,
    input  logic             empty1,
    input  logic             empty2,
    input  logic             empty3,
    input  logic [11:0]      data_in0,
    input  logic [11:0]      data_in1,
    input  logic [11:0]      data_in2,
    input  logic [11:0]      data_in3,
    output logic             pop0,
    output logic             pop1,
    output logic             pop2,
    output logic             pop3,
    output logic [15:0]      frame_data,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [SEQ_W-1:0] seq_num,
    output logic             idle
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;

    state_t           state_q;
    logic [11:0]      pay_q;
    logic [1:0]       ch_q;
    logic [1:0]       ptr_q;
    logic [SEQ_W-1:0] seq_q;
    logic [15:0]      frame_data_q;
    logic             frame_valid_q;

    logic [3:0]       req;
    logic [11:0]      din [4];
    logic             grant_opp;
    logic             found;
    logic             grant;
    logic [1:0]       sel;
    logic [1:0]       idx;
    logic [3:0]       pop;
    logic [SEQ_W-1:0] seq_d;

    assign din[0] = data_in0;
    assign din[1] = data_in1;
    assign din[2] = data_in2;
    assign din[3] = data_in3;

    // Round-robin grant search starting at ptr; grants only at a grant opportunity.
    always_comb begin
        req       = ~{empty3, empty2, empty1, empty0};
        grant_opp = (state_q == IDLE) || ((state_q == TRL) && frame_ready);
        found     = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + i[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        grant = found && grant_opp && active && reset_L;
        pop   = '0;
        if (grant) begin
            pop[sel] = 1'b1;
        end
        seq_d = seq_q + 1'b1;
    end

    assign {pop3, pop2, pop1, pop0} = pop;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign seq_num     = seq_q;
    assign idle        = (state_q == IDLE) && !grant;

    // Frame FSM; frame_data is registered and loaded with the next beat on each transition.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            pay_q         <= '0;
            ch_q          <= '0;
            ptr_q         <= '0;
            seq_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        pay_q         <= din[sel];
                        ch_q          <= sel;
                        ptr_q         <= sel + 2'd1;
                        frame_data_q  <= {4'hA, seq_q, 2'b00, sel};
                        frame_valid_q <= 1'b1;
                        state_q       <= HDR;
                    end
                end
                HDR: begin
                    if (frame_ready) begin
                        frame_data_q <= {4'h0, pay_q};
                        state_q      <= PAY;
                    end
                end
                PAY: begin
                    if (frame_ready) begin
                        frame_data_q <= {4'hF, ~pay_q ^ {seq_q, 2'b00, ch_q}};
                        state_q      <= TRL;
                    end
                end
                TRL: begin
                    if (frame_ready) begin
                        seq_q <= seq_d;
                        // Back-to-back: the next header already carries the incremented sequence.
                        if (grant) begin
                            pay_q         <= din[sel];
                            ch_q          <= sel;
                            ptr_q         <= sel + 2'd1;
                            frame_data_q  <= {4'hA, seq_d, 2'b00, sel};
                            frame_valid_q <= 1'b1;
                            state_q       <= HDR;
                        end else begin
                            frame_data_q  <= '0;
                            frame_valid_q <= 1'b0;
                            state_q       <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tlp_framer.md
# tlp_framer

Link-side framing stage fed by the four transaction-layer output FIFOs (one per traffic class). Each cycle it may pop one 12-bit word from a non-empty FIFO, selected round-robin. Each popped word becomes a 3-beat, 16-bit frame: header, payload and check trailer. Frames are presented to the downstream data-link stage over a valid/ready handshake.

## Interface
Parameters:
- SEQ_W, 8, sequence-number width; fixed at 8 because the header and trailer formats depend on it.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- active  in  1  high when the transaction layer's state machine is in its active state; gates the start of new frames.
- empty0..empty3  in  1 each  empty flags of output FIFOs 0..3.
- data_in0..data_in3  in  12 each  head word of each FIFO. The FIFOs are show-ahead: the word is valid while the FIFO is not empty and is consumed on the edge where pop is high.
- pop0..pop3  out  1 each  combinational pop strobes; at most one is high in any cycle.
- frame_data  out  16  current beat.
- frame_valid  out  1  beat valid.
- frame_ready  in  1  downstream accepts the beat when valid and ready are both high.
- seq_num  out  8  sequence number of the next frame to be built.
- idle  out  1  high in IDLE state with no pop pending.

## Operation
- FSM states: IDLE, HDR, PAY, TRL.
- A grant opportunity exists:
  - in IDLE, or
  - in TRL when the trailer beat is accepted.
- At a grant opportunity, if active is high and any emptyN is low:
  - select channel ch by round-robin, searching from ptr, ptr+1, … mod 4;
  - drive pop[ch]=1 in that cycle;
  - on the edge: latch data_in[ch] into pay_reg, latch ch, set ptr = ch+1 (mod 4), go to HDR.
- At a grant opportunity with no grant:
  - IDLE stays in IDLE;
  - TRL goes to IDLE.
- Beat formats (SEQ = seq value captured with the frame):
  - HDR: {4'hA, SEQ[7:0], 2'b00, ch[1:0]}.
  - PAY: {4'h0, pay_reg[11:0]}.
  - TRL: {4'hF, chk}, where chk = ~pay_reg ^ {SEQ[7:0], 2'b00, ch[1:0]}.
- State transitions:
  - HDR goes to PAY on acceptance.
  - PAY goes to TRL on acceptance.
  - Unaccepted beats hold frame_data stable.
- seq_num increments by 1 when the trailer is accepted; it wraps 255→0 with no flag.
- active falling mid-frame does not abort the frame: it completes, then no new grant is made.
- data_in is sampled only in the pop cycle. Changes to empty or data_in during HDR/PAY/TRL are ignored.
- reset_L low at any point:
  - immediately: state=IDLE, frame_valid=0, frame_data=16'h0, pops=0, seq=0, ptr=0, idle=1;
  - any partial frame is discarded.

## Timing
- Pop in cycle T gives the header valid in T+1.
- With frame_ready held high:
  - HDR in T+1, PAY in T+2, TRL in T+3;
  - the next pop may occur in T+3, the same cycle as the trailer is accepted, so the next header is in T+4.
- Sustained throughput: 3 cycles per word, no bubbles.
- frame_valid is high in HDR, PAY and TRL; it never drops while a beat is unaccepted.
- pop is high only in a cycle where the state is IDLE or (TRL and frame_ready is high), active is high, and the selected emptyN is low.
- idle is combinational: (state==IDLE) and no grant this cycle.

## Test plan
- Reset and single word: release reset, empty0=0, data_in0=12'h5A3, ready=1, active=1. Expect:
  - pop0 for 1 cycle;
  - beats 16'hA000, 16'h05A3, then 16'hFA5C (~5A3=A5C);
  - seq_num 0→1;
  - idle high again after the trailer.
- Round-robin: all four FIFOs non-empty, ready=1. Expect:
  - pop order 0,1,2,3,0…;
  - header channel fields match;
  - a new header every 3 cycles with no idle cycles between frames.
- Backpressure: ready low for 4 cycles during PAY. Expect frame_data to hold the PAY value and valid to stay high, with no pops; TRL follows 1 cycle after ready rises.
- Sequence wrap: send 257 frames on channel 2. Expect:
  - frame 256 header 16'hAFF2;
  - frame 257 header 16'hA002;
  - trailer chk consistent with the seq field.
- active and reset: drop active during HDR. Expect the frame to complete and no further pop while FIFOs stay non-empty. Then pulse reset_L low during PAY; expect frame_valid=0 and seq_num=0 immediately, and ptr=0 so the next grant goes to channel 0.
